// File: rtl/router_a_pkg.sv
// Shared select encodings, default widths and the write-strobe rule for the
// Kalman datapath operand/address router.
package router_a_pkg;

    localparam int unsigned W_DEF     = 24;
    localparam int unsigned ADDRW_DEF = 5;

    localparam logic [1:0] SEL_DATA_IN   = 2'd0;
    localparam logic [1:0] SEL_DATA_RES  = 2'd1;
    localparam logic [1:0] SEL_DATA_ZERO = 2'd2;
    localparam logic [1:0] SEL_DATA_RES2 = 2'd3;

    localparam logic [1:0] SEL_WR_REQ     = 2'd0;
    localparam logic [1:0] SEL_WR_REQ_RDY = 2'd1;
    localparam logic [1:0] SEL_WR_NONE    = 2'd2;
    localparam logic [1:0] SEL_WR_FORCE   = 2'd3;

    function automatic logic wr_strobe(input logic [1:0] sel, input logic req,
                                       input logic rdy);
        logic s;
        unique case (sel)
            SEL_WR_REQ:     s = req;
            SEL_WR_REQ_RDY: s = req & rdy;
            SEL_WR_NONE:    s = 1'b0;
            default:        s = 1'b1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/router_mux2.sv
// Parameterised-width 2:1 mux used for the data-bank address ports.
module router_mux2 #(
    parameter int unsigned Width = 5
) (
    input  logic [Width-1:0] in0_i,
    input  logic [Width-1:0] in1_i,
    input  logic             sel_i,
    output logic [Width-1:0] out_o
);

    assign out_o = sel_i ? in1_i : in0_i;

endmodule

// File: rtl/router_a.sv
// Operand/address router feeding the data bank; optional output register
// stage retimes all outputs by one clock.
module router_a
    import router_a_pkg::*;
#(
    parameter int unsigned W       = W_DEF,
    parameter int unsigned ADDRW   = ADDRW_DEF,
    parameter int unsigned REG_OUT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     DATA_IN,
    input  logic [W-1:0]     RESULT,
    input  logic [ADDRW-1:0] CTL_A,
    input  logic [ADDRW-1:0] CTL_B,
    input  logic [ADDRW-1:0] DIR_EXT,
    input  logic             WRITE_REQ,
    input  logic             READY,
    input  logic [1:0]       sel_data,
    input  logic             sel_dira,
    input  logic             sel_dirb,
    input  logic [1:0]       sel_write,
    output logic [W-1:0]     db_data,
    output logic [ADDRW-1:0] db_dira,
    output logic [ADDRW-1:0] db_dirb,
    output logic             db_write
);

    logic [W-1:0]     data_d;
    logic [ADDRW-1:0] dira_d;
    logic [ADDRW-1:0] dirb_d;
    logic             write_d;

    always_comb begin
        data_d = '0;
        unique case (sel_data)
            SEL_DATA_IN:   data_d = DATA_IN;
            SEL_DATA_RES:  data_d = RESULT;
            SEL_DATA_ZERO: data_d = '0;
            default:       data_d = RESULT;
        endcase
        write_d = wr_strobe(sel_write, WRITE_REQ, READY);
    end

    router_mux2 #(.Width(ADDRW)) u_mux_dira (
        .in0_i (CTL_A),
        .in1_i (DIR_EXT),
        .sel_i (sel_dira),
        .out_o (dira_d)
    );

    router_mux2 #(.Width(ADDRW)) u_mux_dirb (
        .in0_i (CTL_B),
        .in1_i (DIR_EXT),
        .sel_i (sel_dirb),
        .out_o (dirb_d)
    );

    if (REG_OUT != 0) begin : g_reg_out
        logic [W-1:0]     data_q;
        logic [ADDRW-1:0] dira_q;
        logic [ADDRW-1:0] dirb_q;
        logic             write_q;

        // Async clear drops a pending write immediately.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                data_q  <= '0;
                dira_q  <= '0;
                dirb_q  <= '0;
                write_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                dira_q  <= dira_d;
                dirb_q  <= dirb_d;
                write_q <= write_d;
            end
        end

        assign db_data  = data_q;
        assign db_dira  = dira_q;
        assign db_dirb  = dirb_q;
        assign db_write = write_q;
    end else begin : g_comb_out
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;

        assign db_data  = data_d;
        assign db_dira  = dira_d;
        assign db_dirb  = dirb_d;
        assign db_write = write_d;
    end

endmodule

// File: tb/tb_router_a.sv
// Self-checking bench: a combinational and a registered router instance share
// the same stimulus and are compared against a rule-level reference model.
module tb_router_a;
    import router_a_pkg::*;

    localparam int W  = 24;
    localparam int AW = 5;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [AW-1:0] dira;
        logic [AW-1:0] dirb;
        logic          wr;
    } out_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [W-1:0]  DATA_IN, RESULT;
    logic [AW-1:0] CTL_A, CTL_B, DIR_EXT;
    logic          WRITE_REQ, READY;
    logic [1:0]    sel_data, sel_write;
    logic          sel_dira, sel_dirb;

    logic [W-1:0]  c_data, r_data;
    logic [AW-1:0] c_dira, c_dirb, r_dira, r_dirb;
    logic          c_write, r_write;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_a #(.W(W), .ADDRW(AW), .REG_OUT(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .DATA_IN(DATA_IN), .RESULT(RESULT),
        .CTL_A(CTL_A), .CTL_B(CTL_B), .DIR_EXT(DIR_EXT),
        .WRITE_REQ(WRITE_REQ), .READY(READY), .sel_data(sel_data),
        .sel_dira(sel_dira), .sel_dirb(sel_dirb), .sel_write(sel_write),
        .db_data(c_data), .db_dira(c_dira), .db_dirb(c_dirb), .db_write(c_write)
    );

    router_a #(.W(W), .ADDRW(AW), .REG_OUT(1)) u_reg (
        .clk(clk), .rst_n(rst_n), .DATA_IN(DATA_IN), .RESULT(RESULT),
        .CTL_A(CTL_A), .CTL_B(CTL_B), .DIR_EXT(DIR_EXT),
        .WRITE_REQ(WRITE_REQ), .READY(READY), .sel_data(sel_data),
        .sel_dira(sel_dira), .sel_dirb(sel_dirb), .sel_write(sel_write),
        .db_data(r_data), .db_dira(r_dira), .db_dirb(r_dirb), .db_write(r_write)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the routing rules written directly as arithmetic on the inputs.
    function automatic out_t model_now();
        out_t o;
        o.data = (sel_data == 2'd2) ? '0 : ((sel_data == 2'd0) ? DATA_IN : RESULT);
        o.dira = sel_dira ? DIR_EXT : CTL_A;
        o.dirb = sel_dirb ? DIR_EXT : CTL_B;
        if (sel_write == 2'd0)      o.wr = WRITE_REQ;
        else if (sel_write == 2'd1) o.wr = (WRITE_REQ + READY == 2);
        else                        o.wr = (sel_write == 2'd3);
        return o;
    endfunction

    task automatic randomize_inputs();
        DATA_IN   = W'($urandom);
        RESULT    = W'($urandom);
        CTL_A     = AW'($urandom);
        CTL_B     = AW'($urandom);
        DIR_EXT   = AW'($urandom);
        WRITE_REQ = 1'($urandom);
        READY     = 1'($urandom);
        sel_data  = 2'($urandom);
        sel_dira  = 1'($urandom);
        sel_dirb  = 1'($urandom);
        sel_write = 2'($urandom);
    endtask

    task automatic check_comb(input string tag);
        out_t e;
        e = model_now();
        check(tag, 64'({c_data, c_dira, c_dirb, c_write}), 64'(e));
    endtask

    initial begin
        out_t exp_q;
        rst_n = 1'b0;
        randomize_inputs();

        // Registered outputs held at zero while reset is low, across clock edges.
        for (int i = 0; i < 4; i++) begin
            randomize_inputs();
            sel_write = 2'd3;
            #7;
            check("rst_hold", 64'({r_data, r_dira, r_dirb, r_write}), 64'd0);
            check("rst_comb_live", 64'({c_data, c_dira, c_dirb, c_write}), 64'(model_now()));
        end

        DATA_IN = 24'h123456; RESULT = 24'hC0FFEE;
        CTL_A = 5'h03; CTL_B = 5'h1C; DIR_EXT = 5'h12;
        WRITE_REQ = 1'b0; READY = 1'b0; sel_dira = 1'b0; sel_dirb = 1'b0; sel_write = 2'd0;

        for (int s = 0; s < 4; s++) begin
            logic [W-1:0] exp_tab [4];
            exp_tab[0] = 24'h123456; exp_tab[1] = 24'hC0FFEE;
            exp_tab[2] = 24'h000000; exp_tab[3] = 24'hC0FFEE;
            sel_data = 2'(s);
            #1 check("sel_data", 64'(c_data), 64'(exp_tab[s]));
        end

        for (int s = 0; s < 4; s++) begin
            sel_dira = s[0]; sel_dirb = s[1];
            #1;
            check("dira", 64'(c_dira), s[0] ? 64'h12 : 64'h03);
            check("dirb", 64'(c_dirb), s[1] ? 64'h12 : 64'h1C);
        end

        for (int m = 0; m < 4; m++) begin
            for (int k = 0; k < 4; k++) begin
                logic exp_w;
                sel_write = 2'(m); WRITE_REQ = k[1]; READY = k[0];
                case (m)
                    0:       exp_w = k[1];
                    1:       exp_w = k[1] && k[0];
                    2:       exp_w = 1'b0;
                    default: exp_w = 1'b1;
                endcase
                #1 check("wr_mode", 64'(c_write), 64'(exp_w));
            end
        end

        for (int i = 0; i < 256; i++) begin
            logic [7:0] v;
            v = 8'(i);
            DATA_IN = W'($urandom); RESULT = W'($urandom);
            CTL_A = AW'($urandom); CTL_B = AW'($urandom); DIR_EXT = AW'($urandom);
            {sel_data, sel_dira, sel_dirb, sel_write, WRITE_REQ, READY} = v;
            #1 check_comb("exhaustive");
        end

        // Release reset between edges; forced write appears one edge later.
        @(negedge clk);
        sel_write = 2'd3;
        rst_n = 1'b1;
        #1 check("reg_pre_edge", 64'(r_write), 64'd0);
        @(posedge clk);
        #1 check("reg_first_edge", 64'(r_write), 64'd1);

        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            randomize_inputs();
            exp_q = model_now();
            #1 check("reg_hold_prev", 64'(r_write), 64'(r_write));
            @(posedge clk);
            #1;
            check("reg_stream", 64'({r_data, r_dira, r_dirb, r_write}), 64'(exp_q));
            check_comb("comb_stream");
        end

        @(negedge clk);
        randomize_inputs();
        sel_write = 2'd3;
        @(posedge clk);
        #1 check("reg_write_set", 64'(r_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_write", 64'(r_write), 64'd0);
        check("mid_rst_all", 64'({r_data, r_dira, r_dirb, r_write}), 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("post_rst_write", 64'(r_write), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
